// File: rtl/usr_ctrl_pkg.sv
// rtl/usr_ctrl_pkg.sv - shared state, select codes and sizing helper for the shift controller
package usr_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } ctrl_state_t;

    // Select codes understood by the universal shift register.
    localparam logic [1:0] SEL_HOLD  = 2'd0;
    localparam logic [1:0] SEL_RIGHT = 2'd1;
    localparam logic [1:0] SEL_LEFT  = 2'd2;
    localparam logic [1:0] SEL_LOAD  = 2'd3;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/usr_bit_timer.sv
// rtl/usr_bit_timer.sv - bit-period divider with clear input and period-end strobe
module usr_bit_timer
    import usr_ctrl_pkg::*;
#(
    parameter int BIT_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic period_end
);

    localparam int DIV_W = cnt_width(BIT_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    // Strobe is a pure decode of the counter so the shift code never depends on inputs.
    assign period_end = run && (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (clear) begin
            div_cnt <= '0;
        end else if (run) begin
            div_cnt <= period_end ? '0 : div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/usr_shift_controller.sv
// rtl/usr_shift_controller.sv - command-driven sequencer producing select codes for a universal shift register
module usr_shift_controller
    import usr_ctrl_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int BIT_DIV = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_op,
    input  logic             cmd_msb_first,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [1:0]       sr_select,
    output logic [WIDTH-1:0] sr_p_din,
    input  logic [WIDTH-1:0] sr_p_dout,
    output logic             ser_msb_first,
    output logic             busy,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data
);

    localparam int BIT_W = cnt_width(WIDTH);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    ctrl_state_t      state;
    logic [BIT_W-1:0] bit_cnt;
    logic             bit_end;
    logic             in_shift;

    assign in_shift  = (state == ST_SHIFT);
    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

    // Divider is held cleared outside SHIFT so every bit period starts aligned.
    usr_bit_timer #(
        .BIT_DIV (BIT_DIV)
    ) u_bit_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (!in_shift),
        .run        (in_shift),
        .period_end (bit_end)
    );

    always_comb begin
        sr_select = SEL_HOLD;
        case (state)
            ST_LOAD:  sr_select = SEL_LOAD;
            ST_SHIFT: if (bit_end) sr_select = ser_msb_first ? SEL_LEFT : SEL_RIGHT;
            default:  sr_select = SEL_HOLD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            bit_cnt       <= '0;
            sr_p_din      <= '0;
            ser_msb_first <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_data      <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        sr_p_din      <= cmd_data;
                        ser_msb_first <= cmd_msb_first;
                        bit_cnt       <= '0;
                        state         <= cmd_op ? ST_SHIFT : ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (bit_end) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == BIT_LAST) state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Register has absorbed its final shift by now; capture the received word.
                    rsp_data  <= sr_p_dout;
                    rsp_valid <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
